// File: rtl/axi_tagctrl_aw.sv
// AW channel tag controller: accepts a slave AW, forwards it once to the
// master AW channel and once as a descriptor to the W unit, and tracks the
// number of outstanding write transactions against MaxTxn.
module axi_tagctrl_aw #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned MaxTxn       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [AxiIdWidth-1:0]       aw_slv_id_i,
  input  logic [AxiAddrWidth-1:0]     aw_slv_addr_i,
  input  logic [7:0]                  aw_slv_len_i,
  input  logic [2:0]                  aw_slv_size_i,
  input  logic [1:0]                  aw_slv_burst_i,
  input  logic                        aw_slv_valid_i,
  output logic                        aw_slv_ready_o,
  output logic [AxiIdWidth-1:0]       aw_mst_id_o,
  output logic [AxiAddrWidth-1:0]     aw_mst_addr_o,
  output logic [7:0]                  aw_mst_len_o,
  output logic [2:0]                  aw_mst_size_o,
  output logic [1:0]                  aw_mst_burst_o,
  output logic                        aw_mst_valid_o,
  input  logic                        aw_mst_ready_i,
  output logic [AxiIdWidth-1:0]       desc_id_o,
  output logic [AxiAddrWidth-1:0]     desc_addr_o,
  output logic [7:0]                  desc_len_o,
  output logic [2:0]                  desc_size_o,
  output logic                        desc_valid_o,
  input  logic                        desc_ready_i,
  input  logic                        b_done_i,
  output logic [$clog2(MaxTxn+1)-1:0] outstanding_o
);

  localparam int unsigned CntWidth = $clog2(MaxTxn + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxn);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [AxiIdWidth-1:0]   r_id;
  logic [AxiAddrWidth-1:0] r_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic                    r_aw_done;
  logic                    r_desc_done;
  logic [CntWidth-1:0]     r_cnt;

  logic w_slv_rdy;
  logic w_mst_vld;
  logic w_desc_vld;
  logic w_slv_hs;
  logic w_mst_hs;
  logic w_desc_hs;
  logic w_inc;
  logic w_dec;

  // Ready and valids derive from registered state only, never from a ready.
  assign w_slv_rdy  = (r_state == IDLE) && (r_cnt < CntMax);
  assign w_mst_vld  = (r_state == ISSUE) && !r_aw_done;
  assign w_desc_vld = (r_state == ISSUE) && !r_desc_done;

  assign w_slv_hs  = aw_slv_valid_i && w_slv_rdy;
  assign w_mst_hs  = w_mst_vld && aw_mst_ready_i;
  assign w_desc_hs = w_desc_vld && desc_ready_i;

  // b_done at zero is dropped so the counter cannot wrap.
  assign w_inc = w_slv_hs;
  assign w_dec = b_done_i && (r_cnt != '0);

  assign aw_slv_ready_o = w_slv_rdy;
  assign aw_mst_valid_o = w_mst_vld;
  assign desc_valid_o   = w_desc_vld;
  assign outstanding_o  = r_cnt;

  assign aw_mst_id_o    = r_id;
  assign aw_mst_addr_o  = r_addr;
  assign aw_mst_len_o   = r_len;
  assign aw_mst_size_o  = r_size;
  assign aw_mst_burst_o = r_burst;
  assign desc_id_o      = r_id;
  assign desc_addr_o    = r_addr;
  assign desc_len_o     = r_len;
  assign desc_size_o    = r_size;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave ISSUE once both halves are done or finishing this cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_slv_hs) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if ((r_aw_done || w_mst_hs) && (r_desc_done || w_desc_hs)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the slave AW payload on acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (w_slv_hs) begin
      r_id    <= aw_slv_id_i;
      r_addr  <= aw_slv_addr_i;
      r_len   <= aw_slv_len_i;
      r_size  <= aw_slv_size_i;
      r_burst <= aw_slv_burst_i;
    end
  end

  // Track which halves of the current transaction have been handed off.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_aw_done   <= 1'b0;
      r_desc_done <= 1'b0;
    end else if (w_slv_hs) begin
      r_aw_done   <= 1'b0;
      r_desc_done <= 1'b0;
    end else begin
      if (w_mst_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_desc_hs) begin
        r_desc_done <= 1'b1;
      end
    end
  end

  // Outstanding transaction counter; simultaneous inc and dec cancel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + CntWidth'(1);
    end else if (w_dec && !w_inc) begin
      r_cnt <= r_cnt - CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_axi_tagctrl_aw.sv
// Scoreboard bench for axi_tagctrl_aw: stimulus pushes expected payloads,
// a negedge monitor pops and compares on every master AW / descriptor handshake.
module tb_axi_tagctrl_aw;

  logic        clk;
  logic        rst;
  logic [3:0]  aw_slv_id;
  logic [63:0] aw_slv_addr;
  logic [7:0]  aw_slv_len;
  logic [2:0]  aw_slv_size;
  logic [1:0]  aw_slv_burst;
  logic        aw_slv_valid;
  logic        aw_slv_ready;
  logic [3:0]  aw_mst_id;
  logic [63:0] aw_mst_addr;
  logic [7:0]  aw_mst_len;
  logic [2:0]  aw_mst_size;
  logic [1:0]  aw_mst_burst;
  logic        aw_mst_valid;
  logic        aw_mst_ready;
  logic [3:0]  desc_id;
  logic [63:0] desc_addr;
  logic [7:0]  desc_len;
  logic [2:0]  desc_size;
  logic        desc_valid;
  logic        desc_ready;
  logic        b_done;
  logic [2:0]  outstanding;

  axi_tagctrl_aw #(
    .AxiIdWidth  (4),
    .AxiAddrWidth(64),
    .MaxTxn      (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .aw_slv_id_i   (aw_slv_id),
    .aw_slv_addr_i (aw_slv_addr),
    .aw_slv_len_i  (aw_slv_len),
    .aw_slv_size_i (aw_slv_size),
    .aw_slv_burst_i(aw_slv_burst),
    .aw_slv_valid_i(aw_slv_valid),
    .aw_slv_ready_o(aw_slv_ready),
    .aw_mst_id_o   (aw_mst_id),
    .aw_mst_addr_o (aw_mst_addr),
    .aw_mst_len_o  (aw_mst_len),
    .aw_mst_size_o (aw_mst_size),
    .aw_mst_burst_o(aw_mst_burst),
    .aw_mst_valid_o(aw_mst_valid),
    .aw_mst_ready_i(aw_mst_ready),
    .desc_id_o     (desc_id),
    .desc_addr_o   (desc_addr),
    .desc_len_o    (desc_len),
    .desc_size_o   (desc_size),
    .desc_valid_o  (desc_valid),
    .desc_ready_i  (desc_ready),
    .b_done_i      (b_done),
    .outstanding_o (outstanding)
  );

  typedef struct {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } exp_t;

  exp_t q_aw[$];
  exp_t q_desc[$];
  int   passed = 0;
  int   total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every handshake on either output channel consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (aw_mst_valid && aw_mst_ready) begin
        if (q_aw.size() == 0) begin
          total++;
          $display("FAIL aw_unexpected: got handshake id=%0h expected none", aw_mst_id);
        end else begin
          exp_t e;
          e = q_aw.pop_front();
          chk("aw_id", 64'(aw_mst_id), 64'(e.id));
          chk("aw_addr", aw_mst_addr, e.addr);
          chk("aw_len", 64'(aw_mst_len), 64'(e.len));
          chk("aw_size", 64'(aw_mst_size), 64'(e.size));
          chk("aw_burst", 64'(aw_mst_burst), 64'(e.burst));
        end
      end
      if (desc_valid && desc_ready) begin
        if (q_desc.size() == 0) begin
          total++;
          $display("FAIL desc_unexpected: got handshake id=%0h expected none", desc_id);
        end else begin
          exp_t e;
          e = q_desc.pop_front();
          chk("desc_id", 64'(desc_id), 64'(e.id));
          chk("desc_addr", desc_addr, e.addr);
          chk("desc_len", 64'(desc_len), 64'(e.len));
          chk("desc_size", 64'(desc_size), 64'(e.size));
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_aw(input logic [3:0] id, input logic [63:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b, input bit expect_fwd);
    int n;
    exp_t e;
    e.id = id; e.addr = a; e.len = l; e.size = s; e.burst = b;
    aw_slv_id = id; aw_slv_addr = a; aw_slv_len = l; aw_slv_size = s; aw_slv_burst = b;
    aw_slv_valid = 1'b1;
    if (expect_fwd) begin
      q_aw.push_back(e);
      q_desc.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!aw_slv_ready && n < 50);
    if (!aw_slv_ready) begin
      total++;
      $display("FAIL aw_accept_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
    @(posedge clk);
    #1 aw_slv_valid = 1'b0;
  endtask

  task automatic pulse_bdone();
    b_done = 1'b1;
    @(posedge clk);
    #1 b_done = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    aw_slv_id = '0; aw_slv_addr = '0; aw_slv_len = '0; aw_slv_size = '0; aw_slv_burst = '0;
    aw_slv_valid = 1'b0; aw_mst_ready = 1'b0; desc_ready = 1'b0; b_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_slv_ready", 64'(aw_slv_ready), 64'd1);
    chk("rst_mst_valid", 64'(aw_mst_valid), 64'd0);
    chk("rst_desc_valid", 64'(desc_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_payload", {aw_mst_id, aw_mst_addr[31:0]}, 64'd0);
    rst = 1'b0;
    aw_mst_ready = 1'b1; desc_ready = 1'b1;
    next_cycle();

    // Single write with both readies high.
    send_aw(4'd3, 64'h1000, 8'd3, 3'd3, 2'd1, 1'b1);
    @(negedge clk);
    chk("t1_mst_valid", 64'(aw_mst_valid), 64'd1);
    chk("t1_desc_valid", 64'(desc_valid), 64'd1);
    chk("t1_outstanding", 64'(outstanding), 64'd1);
    chk("t1_slv_ready_issue", 64'(aw_slv_ready), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("t1_mst_valid_pulse", 64'(aw_mst_valid), 64'd0);
    chk("t1_desc_valid_pulse", 64'(desc_valid), 64'd0);
    chk("t1_slv_ready_n2", 64'(aw_slv_ready), 64'd1);
    next_cycle();

    // Skewed handshakes: descriptor side held off for 5 cycles.
    desc_ready = 1'b0;
    send_aw(4'd5, 64'h2000_0000_0000_0040, 8'd7, 3'd2, 2'd2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_mst_valid", 64'(aw_mst_valid), (k == 0) ? 64'd1 : 64'd0);
      chk("t2_desc_held", 64'(desc_valid), 64'd1);
      next_cycle();
    end
    desc_ready = 1'b1;
    @(negedge clk);
    chk("t2_desc_final", 64'(desc_valid), 64'd1);
    chk("t2_still_issue", 64'(aw_slv_ready), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("t2_desc_done", 64'(desc_valid), 64'd0);
    chk("t2_idle_ready", 64'(aw_slv_ready), 64'd1);
    chk("t2_outstanding", 64'(outstanding), 64'd2);
    next_cycle();

    // Drain to zero, then b_done at zero must not wrap.
    pulse_bdone();
    pulse_bdone();
    chk("drain_zero", 64'(outstanding), 64'd0);
    pulse_bdone();
    chk("bdone_at_zero", 64'(outstanding), 64'd0);

    // Limit: four accepted, fifth stalls until one b_done.
    send_aw(4'h1, 64'hA000, 8'd0, 3'd0, 2'd0, 1'b1);
    send_aw(4'h2, 64'hA100, 8'd1, 3'd1, 2'd1, 1'b1);
    send_aw(4'h4, 64'hA200, 8'd2, 3'd2, 2'd2, 1'b1);
    send_aw(4'h8, 64'hA300, 8'd255, 3'd7, 2'd1, 1'b1);
    next_cycle();
    chk("t3_count_max", 64'(outstanding), 64'd4);
    begin
      exp_t e5;
      e5.id = 4'hF; e5.addr = 64'hFFFF_0000_DEAD_BEE0; e5.len = 8'd15; e5.size = 3'd4; e5.burst = 2'd1;
      aw_slv_id = e5.id; aw_slv_addr = e5.addr; aw_slv_len = e5.len;
      aw_slv_size = e5.size; aw_slv_burst = e5.burst;
      aw_slv_valid = 1'b1;
      q_aw.push_back(e5);
      q_desc.push_back(e5);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_ready", 64'(aw_slv_ready), 64'd0);
      chk("t3_stall_count", 64'(outstanding), 64'd4);
      next_cycle();
    end
    b_done = 1'b1;
    @(negedge clk);
    chk("t3_bdone_no_comb_ready", 64'(aw_slv_ready), 64'd0);
    next_cycle();
    b_done = 1'b0;
    @(negedge clk);
    chk("t3_ready_after_bdone", 64'(aw_slv_ready), 64'd1);
    chk("t3_count_dec", 64'(outstanding), 64'd3);
    next_cycle();
    aw_slv_valid = 1'b0;
    chk("t3_count_refill", 64'(outstanding), 64'd4);
    next_cycle();
    repeat (4) pulse_bdone();
    chk("t3_drained", 64'(outstanding), 64'd0);

    // Simultaneous accept and b_done at count 2.
    send_aw(4'h6, 64'hB000, 8'd1, 3'd3, 2'd1, 1'b1);
    send_aw(4'h7, 64'hB040, 8'd1, 3'd3, 2'd1, 1'b1);
    next_cycle();
    chk("t4_count_two", 64'(outstanding), 64'd2);
    b_done = 1'b1;
    send_aw(4'h9, 64'hB080, 8'd2, 3'd3, 2'd0, 1'b1);
    b_done = 1'b0;
    @(negedge clk);
    chk("t4_simultaneous", 64'(outstanding), 64'd2);
    next_cycle();
    next_cycle();
    repeat (2) pulse_bdone();
    chk("t4_drained", 64'(outstanding), 64'd0);

    // Reset while in ISSUE with both halves still pending.
    aw_mst_ready = 1'b0; desc_ready = 1'b0;
    send_aw(4'hC, 64'hC0C0, 8'd9, 3'd1, 2'd2, 1'b0);
    @(negedge clk);
    chk("t5_pre_mst_valid", 64'(aw_mst_valid), 64'd1);
    chk("t5_pre_desc_valid", 64'(desc_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_mst_valid", 64'(aw_mst_valid), 64'd0);
    chk("t5_rst_desc_valid", 64'(desc_valid), 64'd0);
    chk("t5_rst_outstanding", 64'(outstanding), 64'd0);
    chk("t5_rst_slv_ready", 64'(aw_slv_ready), 64'd1);
    chk("t5_rst_payload", aw_mst_addr, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    aw_mst_ready = 1'b1; desc_ready = 1'b1;
    @(negedge clk);
    chk("t5_first_accept_ready", 64'(aw_slv_ready), 64'd1);
    next_cycle();
    send_aw(4'hD, 64'h0123_4567_89AB_CDE0, 8'd5, 3'd2, 2'd1, 1'b1);
    @(negedge clk);
    chk("t5_post_outstanding", 64'(outstanding), 64'd1);
    next_cycle();
    next_cycle();

    chk("sb_aw_empty", 64'(q_aw.size()), 64'd0);
    chk("sb_desc_empty", 64'(q_desc.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
